inst_mem_sync: RTL
==================

INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 8, meaning word-address width.
REQ-002 The block SHALL expose parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL expose parameter DEPTH, default 256, meaning stored words; legal range 1..2**ADDR_W.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port rd_en, input, 1, read request for this cycle.
REQ-008 Port A, input, ADDR_W, read word address.
REQ-009 Port RD, output, DATA_W, registered read data.
REQ-010 Port rd_valid, output, 1, RD holds data for the request accepted one cycle earlier.
REQ-011 Port we, input, 1, load-port write enable.
REQ-012 Port WA, input, ADDR_W, load-port word address.
REQ-013 Port WD, input, DATA_W, load-port write data.
REQ-014 Port ready, output, 1, the block accepts reads and writes.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 Reset SHALL put the FSM in CLEAR with the internal clear counter at 0.
REQ-017 In CLEAR, each cycle SHALL write 0 to the word at the clear counter, then increment the counter.
REQ-018 CLEAR SHALL move to RUN on the cycle it writes word DEPTH-1, so CLEAR lasts exactly DEPTH cycles after rst deasserts.
REQ-019 In RUN, the FSM SHALL stay in RUN until rst is asserted.
REQ-020 ready SHALL be 1 exactly when the FSM is in RUN.
REQ-021 While ready=0, rd_en and we SHALL be ignored: no write, rd_valid=0 on the next cycle.
REQ-022 A read SHALL be accepted in any cycle with ready=1 and rd_en=1.
REQ-023 For an accepted read, RD and rd_valid=1 SHALL appear on the next edge; latency is one cycle.
REQ-024 Back-to-back reads SHALL be supported at one per cycle.
REQ-025 In a cycle with no accepted read, rd_valid SHALL go to 0 and RD SHALL hold its last value.
REQ-026 A read with A >= DEPTH SHALL return RD=0 with rd_valid=1.
REQ-027 A write SHALL occur when ready=1, we=1 and WA < DEPTH: mem[WA] <= WD.
REQ-028 A write with WA >= DEPTH SHALL be discarded with no side effect.
REQ-029 A simultaneous accepted read and write to the same address SHALL be write-first: RD returns WD.
REQ-030 A simultaneous accepted read and write to different addresses SHALL complete both in the same cycle.
REQ-031 Asserting rst mid-operation SHALL abort any read, force rd_valid=0 next cycle, and restart CLEAR from counter 0.

Reset
REQ-032 After a reset edge, the outputs SHALL be RD=0, rd_valid=0 and ready=0.
REQ-033 Memory contents after reset SHALL be all zero once ready first rises; they are not guaranteed earlier.
REQ-034 The first cycle with rst=0 SHALL be clear cycle 0.

Verification
REQ-035 Default params, rst high 2 cycles then low -> ready=0 for 256 cycles then 1; reading addresses 0..255 -> RD=0 each, rd_valid=1 one cycle after each request.
REQ-036 Program load test -> after ready:
- write 0x20010003 @0 and 0x20020009 @1 via the load port;
- read 0 then 1 on consecutive cycles -> RD=0x20010003 then 0x20020009, rd_valid high two consecutive cycles.
REQ-037 Collision test -> same-cycle we=1 WA=5 WD=0xDEADBEEF with rd_en=1 A=5 -> next cycle RD=0xDEADBEEF, rd_valid=1.
REQ-038 DEPTH=14, ADDR_W=8 -> read A=20 gives RD=0; write WA=20 then read A=20 gives RD=0; read A=13 is unaffected.
REQ-039 Mid-run reset test -> load 0x12345678 @3, pulse rst 1 cycle while rd_en=1:
- next cycle rd_valid=0, ready=0;
- ready returns after DEPTH cycles;
- read @3 gives 0.
REQ-040 Requests while ready=0 (rd_en=1, we=1 WA=2 WD=0xFFFFFFFF during CLEAR) -> rd_valid stays 0; after ready, read @2 gives 0.

Source files
------------

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with a one-cycle read port and a load/write port.
// After reset the array is zero-filled one word per cycle before reads and writes are accepted.
module inst_mem_sync #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] RD,
    output logic              rd_valid,
    input  logic              we,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    output logic              ready
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAST  = DEPTH - 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                rd_valid_q, rd_valid_d;
    logic                ready_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [IDX_W-1:0]    mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                rd_in_range;
    logic                wr_in_range;
    logic                rd_accept;
    logic                wr_accept;

    assign rd_in_range = (32'(A)  < DEPTH);
    assign wr_in_range = (32'(WA) < DEPTH);

    // Next-state, memory write port and read-data selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = '0;
        mem_wd     = '0;
        rd_accept  = 1'b0;
        wr_accept  = 1'b0;

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = IDX_W'(cnt_q);
                cnt_d  = cnt_q + ADDR_W'(1);
                if (32'(cnt_q) == LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rd_accept = rd_en;
                wr_accept = we && wr_in_range;
                if (wr_accept) begin
                    mem_we = 1'b1;
                    mem_wa = IDX_W'(WA);
                    mem_wd = WD;
                end
                if (rd_accept) begin
                    rd_valid_d = 1'b1;
                    if (!rd_in_range) begin
                        rd_d = '0;
                    end else if (wr_accept && (WA == A)) begin
                        // write-first bypass on a same-address collision
                        rd_d = WD;
                    end else begin
                        rd_d = mem[IDX_W'(A)];
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase

        // reset wins over any activity in the same cycle
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= (state_d == S_RUN);
        end
    end

    // Storage array, intentionally without reset; contents are defined by the clear sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign RD       = rd_q;
    assign rd_valid = rd_valid_q;
    assign ready    = ready_q;

endmodule
